pwm_ramp_controller: RTL and testbench

Sequencer for a bank of PWM channels. It owns the shared period counter and the per-channel duty values, and ramps each channel from its current duty toward a host-written target by a fixed step once per PWM period. New duty values commit to all channels simultaneously at the period wrap, so no channel ever sees a mid-period change. The block sits between the host register interface and the PWM channel instances, driving their `value` inputs.

---
 rtl/pwm_pkg.sv | 10 +
 rtl/pwm_ramp_step.sv | 18 +
 rtl/pwm_ramp_controller.sv | 86 ++++++++
 tb/tb_pwm_ramp_controller.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared FSM state type, default width and index width helper for the PWM ramp controller.
package pwm_pkg;
    typedef enum logic {IDLE, CALC} state_t;

    localparam int DEF_WIDTH = 16;

    function automatic int ch_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/pwm_ramp_step.sv
// pwm_ramp_step: moves value one step toward target, clamping at target so it never overshoots or wraps.
module pwm_ramp_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] value,
    input  logic [WIDTH-1:0] target,
    input  logic [WIDTH-1:0] step,
    output logic [WIDTH-1:0] next
);
    logic             up;
    logic [WIDTH-1:0] diff;

    always_comb begin
        up   = target > value;
        diff = up ? target - value : value - target;
        next = (step == '0 || diff <= step) ? target : (up ? value + step : value - step);
    end
endmodule

// File: rtl/pwm_ramp_controller.sv
// pwm_ramp_controller: shared period counter, per-channel ramp sequencing through one step unit,
// and simultaneous commit of all duty values at the period wrap.
module pwm_ramp_controller
    import pwm_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = DEF_WIDTH,
    parameter int CH_W   = ch_w(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [CH_W-1:0]         wr_ch,
    input  logic [WIDTH-1:0]        wr_target,
    input  logic [WIDTH-1:0]        wr_step,
    output logic [NUM_CH*WIDTH-1:0] value,
    output logic [NUM_CH-1:0]       busy,
    output logic                    period_start
);
    localparam int IW = ch_w(NUM_CH);

    state_t           state, state_nx;
    logic [WIDTH-1:0] cnt;
    logic [IW-1:0]    idx;
    logic             last;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] tgt [NUM_CH];
    logic [WIDTH-1:0] stp [NUM_CH];
    logic [WIDTH-1:0] shd [NUM_CH];
    logic [WIDTH-1:0] cur [NUM_CH];

    assign last         = idx == IW'(NUM_CH - 1);
    assign wr_ready     = state == IDLE;
    assign period_start = cnt == '0;

    always_comb begin
        state_nx = (state == IDLE) ? (cnt == '0 ? CALC : IDLE) : (last ? IDLE : CALC);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt + 1'b1;
            idx   <= (state == CALC && !last) ? idx + 1'b1 : '0;
        end
    end

    pwm_ramp_step #(.WIDTH(WIDTH)) u_step (
        .value (cur[idx]),
        .target(tgt[idx]),
        .step  (stp[idx]),
        .next  (nxt)
    );

    // Out-of-range channel writes match no n and are silently dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < NUM_CH; n++) begin
                tgt[n]  <= '0;
                stp[n]  <= '0;
                shd[n]  <= '0;
                cur[n]  <= '0;
                busy[n] <= 1'b0;
            end
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (wr_valid && wr_ready && 32'(wr_ch) == n) begin
                    tgt[n] <= wr_target;
                    stp[n] <= wr_step;
                end
                if (state == CALC && 32'(idx) == n) shd[n] <= nxt;
                if (cnt == '1) cur[n] <= shd[n];
                busy[n] <= cur[n] != tgt[n];
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        assign value[g*WIDTH +: WIDTH] = cur[g];
    end
endmodule

// File: tb/tb_pwm_ramp_controller.sv
// tb_pwm_ramp_controller: directed and randomized checks of the ramp controller against a period-level model.
module tb_pwm_ramp_controller;
    localparam int NC = 4;
    localparam int W  = 8;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [CW-1:0] wr_ch = '0;
    logic [W-1:0]  wr_target = '0;
    logic [W-1:0]  wr_step = '0;
    logic [NC*W-1:0] value;
    logic [NC-1:0] busy;
    logic          period_start;

    int n_cmp = 0;
    int n_bad = 0;
    int mc;
    int m_tgt [NC];
    int m_stp [NC];
    int m_val [NC];
    int m_shd [NC];
    logic [NC-1:0] m_busy;

    pwm_ramp_controller #(.NUM_CH(NC), .WIDTH(W), .CH_W(CW)) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_ch(wr_ch),
        .wr_target(wr_target), .wr_step(wr_step), .value(value), .busy(busy),
        .period_start(period_start)
    );

    always #5 clk = ~clk;

    function automatic int ref_step(int v, int t, int s);
        int d = t - v;
        if (s == 0 || (d < 0 ? -d : d) <= s) return t;
        return d > 0 ? v + s : v - s;
    endfunction

    function automatic logic [W-1:0] dv(int n);
        return value[n*W +: W];
    endfunction

    task automatic model_reset();
        mc = 0;
        m_busy = '0;
        for (int n = 0; n < NC; n++) begin
            m_tgt[n] = 0; m_stp[n] = 0; m_val[n] = 0; m_shd[n] = 0;
        end
    endtask

    // Advances one clock from negedge to negedge; writes land only outside counts 1..NC.
    task automatic step_cyc();
        logic acc;
        logic [NC-1:0] nb;
        int oc;
        acc = wr_valid && !(mc >= 1 && mc <= NC);
        for (int n = 0; n < NC; n++) nb[n] = m_val[n] != m_tgt[n];
        oc = mc;
        @(posedge clk);
        m_busy = nb;
        if (oc == 255) for (int n = 0; n < NC; n++) m_val[n] = m_shd[n];
        if (oc == 1) for (int n = 0; n < NC; n++) m_shd[n] = ref_step(m_val[n], m_tgt[n], m_stp[n]);
        if (acc && int'(wr_ch) < NC) begin
            m_tgt[int'(wr_ch)] = int'(wr_target);
            m_stp[int'(wr_ch)] = int'(wr_step);
        end
        mc = (mc + 1) % 256;
        @(negedge clk);
    endtask

    task automatic wait_cnt(int c);
        for (int k = 0; k < 256; k++) begin
            step_cyc();
            if (mc == c) break;
        end
    endtask

    task automatic do_write(int ch, int t, int s);
        wr_valid = 1'b1; wr_ch = CW'(ch); wr_target = W'(t); wr_step = W'(s);
        step_cyc();
        wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (value !== '0) begin n_bad++; $display("FAIL reset_value: got %h want 0", value); end
        n_cmp++; if (busy !== '0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", wr_ready); end
        n_cmp++; if (period_start !== 1'b1) begin n_bad++; $display("FAIL reset_ps: got %b want 1", period_start); end
        rst = 1'b0;
        model_reset();
        n_cmp++; if (period_start !== 1'b1) begin n_bad++; $display("FAIL ps_first: got %b want 1", period_start); end
        step_cyc();
        n_cmp++; if (period_start !== 1'b0) begin n_bad++; $display("FAIL ps_second: got %b want 0", period_start); end
        repeat (255) step_cyc();
        n_cmp++; if (period_start !== 1'b1) begin n_bad++; $display("FAIL ps_wrap: got %b want 1", period_start); end
    endtask

    task automatic test_jump();
        do_write(1, 100, 0);
        step_cyc();
        n_cmp++; if (busy[1] !== 1'b1) begin n_bad++; $display("FAIL jump_busy_wait: got %b want 1", busy[1]); end
        wait_cnt(0);
        n_cmp++; if (dv(1) !== 8'd100) begin n_bad++; $display("FAIL jump_value: got %0d want 100", dv(1)); end
        n_cmp++; if (busy[1] !== 1'b1) begin n_bad++; $display("FAIL jump_busy_commit: got %b want 1", busy[1]); end
        step_cyc();
        n_cmp++; if (busy[1] !== 1'b0) begin n_bad++; $display("FAIL jump_busy_drop: got %b want 0", busy[1]); end
        wait_cnt(10);
        do_write(1, 40, 0);
        wait_cnt(0);
        n_cmp++; if (dv(1) !== 8'd100) begin n_bad++; $display("FAIL late_hold: got %0d want 100", dv(1)); end
        wait_cnt(0);
        n_cmp++; if (dv(1) !== 8'd40) begin n_bad++; $display("FAIL late_value: got %0d want 40", dv(1)); end
    endtask

    task automatic test_ramp_up();
        int exp_v [5] = '{3, 6, 9, 10, 10};
        do_write(0, 10, 3);
        for (int k = 0; k < 5; k++) begin
            wait_cnt(0);
            n_cmp++; if (dv(0) !== W'(exp_v[k]) || int'(dv(0)) != m_val[0]) begin
                n_bad++; $display("FAIL ramp_up[%0d]: got %0d want %0d", k, dv(0), exp_v[k]);
            end
            if (k == 3) begin
                step_cyc();
                n_cmp++; if (busy[0] !== 1'b0) begin n_bad++; $display("FAIL ramp_up_busy: got %b want 0", busy[0]); end
            end
        end
    endtask

    task automatic test_ramp_down();
        int exp_v [4] = '{150, 50, 0, 0};
        do_write(2, 250, 0);
        wait_cnt(0);
        n_cmp++; if (dv(2) !== 8'd250) begin n_bad++; $display("FAIL down_jump: got %0d want 250", dv(2)); end
        do_write(2, 0, 100);
        for (int k = 0; k < 4; k++) begin
            wait_cnt(0);
            n_cmp++; if (dv(2) !== W'(exp_v[k])) begin
                n_bad++; $display("FAIL ramp_down[%0d]: got %0d want %0d", k, dv(2), exp_v[k]);
            end
        end
    endtask

    task automatic test_blocked();
        logic [NC*W-1:0] snap;
        step_cyc();
        wr_valid = 1'b1; wr_ch = 3'd3; wr_target = 8'd77; wr_step = 8'd0;
        while (mc >= 1 && mc <= NC) begin
            n_cmp++; if (wr_ready !== 1'b0) begin n_bad++; $display("FAIL blocked_ready@%0d: got %b want 0", mc, wr_ready); end
            step_cyc();
        end
        n_cmp++; if (wr_ready !== 1'b1 || mc != 5) begin n_bad++; $display("FAIL blocked_accept@%0d: got %b want 1", mc, wr_ready); end
        step_cyc();
        wr_valid = 1'b0;
        wait_cnt(0);
        n_cmp++; if (dv(3) !== 8'd0) begin n_bad++; $display("FAIL blocked_hold: got %0d want 0", dv(3)); end
        wait_cnt(0);
        n_cmp++; if (dv(3) !== 8'd77) begin n_bad++; $display("FAIL blocked_value: got %0d want 77", dv(3)); end
        snap = {8'd77, 8'd0, 8'd40, 8'd10};
        do_write(4, 200, 0);
        wait_cnt(0);
        wait_cnt(0);
        n_cmp++; if (value !== snap) begin n_bad++; $display("FAIL bad_ch_drop: got %h want %h", value, snap); end
    endtask

    task automatic test_reset_mid();
        wait_cnt(0);
        do_write(0, 200, 5);
        wait_cnt(6);
        do_write(1, 0, 7);
        wait_cnt(0);
        n_cmp++; if (dv(0) !== 8'd15 || dv(1) !== 8'd40) begin
            n_bad++; $display("FAIL mid_pre: got %0d/%0d want 15/40", dv(0), dv(1));
        end
        wait_cnt(2);
        rst = 1'b1;
        #2;
        n_cmp++; if (value !== '0) begin n_bad++; $display("FAIL mid_value: got %h want 0", value); end
        n_cmp++; if (busy !== '0) begin n_bad++; $display("FAIL mid_busy: got %b want 0", busy); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            wait_cnt(0);
            n_cmp++; if (value !== '0 || busy !== '0) begin
                n_bad++; $display("FAIL mid_idle[%0d]: got %h/%b want 0/0", k, value, busy);
            end
        end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 2560; cyc++) begin
            if ($urandom_range(0, 9) == 0) begin
                wr_valid = 1'b1;
                wr_ch = CW'($urandom_range(0, 4));
                wr_target = W'($urandom);
                wr_step = W'($urandom_range(0, 60));
            end
            n_cmp++; if (wr_ready !== !(mc >= 1 && mc <= NC) || period_start !== (mc == 0)) begin
                n_bad++; $display("FAIL rnd_ctrl@%0d: got %b%b want %b%b", mc, wr_ready, period_start,
                                  !(mc >= 1 && mc <= NC), mc == 0);
            end
            step_cyc();
            wr_valid = 1'b0;
            if (mc == 0 || mc == 1) begin
                for (int n = 0; n < NC; n++) begin
                    n_cmp++; if (dv(n) !== W'(m_val[n])) begin
                        n_bad++; $display("FAIL rnd_value ch%0d@%0d: got %0d want %0d", n, cyc, dv(n), m_val[n]);
                    end
                end
                n_cmp++; if (busy !== m_busy) begin
                    n_bad++; $display("FAIL rnd_busy@%0d: got %b want %b", cyc, busy, m_busy);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_jump();
        test_ramp_up();
        test_ramp_down();
        test_blocked();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
